mem_traffic_gen: RTL and testbench

MEM_TRAFFIC_GEN -- requirements
Module: mem_traffic_gen

---
 rtl/mem_traffic_gen_pkg.sv | 19 +
 rtl/mem_traffic_gen_sat_counter.sv | 30 +++
 rtl/mem_traffic_gen.sv | 191 +++++++++++++++++++
 tb/tb_mem_traffic_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_traffic_gen_pkg.sv
// ---------------------------------------------------------------------------
// mem_traffic_gen_pkg -- FSM state type and write-pattern seed default. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_traffic_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_PASS = 2'd1,
      ST_RD_PASS = 2'd2,
      ST_FINISH  = 2'd3
   } state_e;

   localparam logic [31:0] C_SEED_DEFAULT = 32'hA5A5_0000;

endpackage

`default_nettype wire

// File: rtl/mem_traffic_gen_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter -- clearable up-counter that sticks at all-ones. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/mem_traffic_gen.sv
// ---------------------------------------------------------------------------
// mem_traffic_gen -- strided read / write-then-read memory traffic generator
// with access/miss statistics; TRAFFIC_CHECK_EN adds read-data checking. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_traffic_gen
   import mem_traffic_gen_pkg::*;
#(
   parameter int          ADDR_W = 15,
   parameter int          WORD_W = 32,
   parameter int          CNT_W  = 16,
   parameter logic [31:0] SEED   = C_SEED_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic [ADDR_W-1:0] stride,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic              mem_hit,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  access_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  error_count
);

   state_e            state_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] end_q;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic              mode_q;
   logic              rd_q;
   logic              wr_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W:0]   w_next_addr;
   logic [ADDR_W-1:0] w_stride_eff;
   logic              w_last;
   logic              w_complete;
   logic              w_accept;

   function automatic logic [WORD_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      return WORD_W'(a) ^ WORD_W'(SEED);
   endfunction

   // Next address is one bit wider so running off the top of memory ends the pass.
   assign w_stride_eff = (stride == '0) ? ADDR_W'(1) : stride;
   assign w_next_addr  = {1'b0, addr_q} + {1'b0, stride_q};
   assign w_last       = w_next_addr[ADDR_W] || (w_next_addr > {1'b0, end_q});
   assign w_complete   = (rd_q || wr_q) && mem_ready;
   assign w_accept     = (state_q == ST_IDLE) && start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         base_q   <= '0;
         end_q    <= '0;
         stride_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mode_q   <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  base_q   <= base_addr;
                  end_q    <= end_addr;
                  stride_q <= w_stride_eff;
                  mode_q   <= mode;
                  busy_q   <= 1'b1;
                  if (base_addr > end_addr) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= mode ? ST_WR_PASS : ST_RD_PASS;
                     addr_q  <= base_addr;
                     rd_q    <= ~mode;
                     wr_q    <= mode;
                     wdata_q <= mode ? pattern(base_addr) : '0;
                  end
               end
            end

            ST_WR_PASS: begin
               if (w_complete) begin
                  if (w_last) begin
                     state_q <= ST_RD_PASS;
                     addr_q  <= base_q;
                     wr_q    <= 1'b0;
                     rd_q    <= 1'b1;
                     wdata_q <= '0;
                  end else begin
                     addr_q  <= w_next_addr[ADDR_W-1:0];
                     wdata_q <= pattern(w_next_addr[ADDR_W-1:0]);
                  end
               end
            end

            ST_RD_PASS: begin
               if (w_complete) begin
                  if (w_last) begin
                     state_q <= ST_FINISH;
                     rd_q    <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     addr_q <= w_next_addr[ADDR_W-1:0];
                  end
               end
            end

            ST_FINISH: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= ST_IDLE;
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_address = addr_q;
   assign mem_read    = rd_q;
   assign mem_write   = wr_q;
   assign mem_wdata   = wdata_q;
   assign busy        = busy_q;
   assign done        = done_q;

   sat_counter #(.CNT_W(CNT_W)) u_access_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_accept),
      .inc     (w_complete),
      .count_o (access_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_accept),
      .inc     (rd_q && mem_ready && !mem_hit),
      .count_o (miss_count)
   );

`ifdef TRAFFIC_CHECK_EN
   logic w_err_inc;

   // Only the read-back pass of a write-then-read run has known expected data.
   assign w_err_inc = rd_q && mem_ready && mode_q && (state_q == ST_RD_PASS) &&
                      (mem_rdata != pattern(addr_q));

   sat_counter #(.CNT_W(CNT_W)) u_error_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_accept),
      .inc     (w_err_inc),
      .count_o (error_count)
   );
`else
   logic w_unused_chk;

   assign w_unused_chk = ^{mem_rdata, mode_q};
   assign error_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_traffic_gen.sv
// ---------------------------------------------------------------------------
// tb_mem_traffic_gen -- randomized self-checking bench against a list-based
// model of the expected request stream and statistics. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_traffic_gen;

   localparam int          ADDR_W = 15;
   localparam int          WORD_W = 32;
   localparam logic [31:0] SEED   = 32'hA5A5_0000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] end_addr = '0;
   logic [ADDR_W-1:0] stride = '0;
   logic [WORD_W-1:0] mem_rdata = '0;
   logic              mem_ready = 1'b0;
   logic              mem_hit = 1'b0;

   logic [ADDR_W-1:0] mem_address, mem_address4;
   logic              mem_read, mem_read4, mem_write, mem_write4;
   logic [WORD_W-1:0] mem_wdata, mem_wdata4;
   logic              busy, busy4, done, done4;
   logic [15:0]       access_count, miss_count, error_count;
   logic [3:0]        access_count4, miss_count4, error_count4;

   always #5 clk = ~clk;

   mem_traffic_gen dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .base_addr(base_addr), .end_addr(end_addr), .stride(stride),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_hit(mem_hit), .busy(busy), .done(done),
      .access_count(access_count), .miss_count(miss_count), .error_count(error_count)
   );

   mem_traffic_gen #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .base_addr(base_addr), .end_addr(end_addr), .stride(stride),
      .mem_address(mem_address4), .mem_read(mem_read4), .mem_write(mem_write4),
      .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_hit(mem_hit), .busy(busy4), .done(done4),
      .access_count(access_count4), .miss_count(miss_count4), .error_count(error_count4)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] pat(input int a);
      return 32'(a) ^ SEED;
   endfunction

   function automatic int sat(input int v, input int w);
      int mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   typedef struct {
      bit wr;
      int addr;
   } req_t;

   // hitm: 0 random hit, 1 always miss, 2 always hit; bad: read address returning corrupted data
   task automatic run(input bit md, input int b, input int e, input int s, input int dly,
                      input int hitm, input int bad);
      req_t        exp_q[$];
      int          addrs[$];
      logic [31:0] mem [int];
      logic [31:0] rd;
      int s_eff = (s == 0) ? 1 : s;
      int n_acc = 0, n_miss = 0, n_err = 0, exp_err;
      int idx = 0, waited = 0, target, cyc, last_cyc = 0, a;
      bit seen = 1'b0, hit;

      for (int x = b; x <= e; x += s_eff) addrs.push_back(x);
      if (md) foreach (addrs[i]) exp_q.push_back('{1'b1, addrs[i]});
      foreach (addrs[i]) exp_q.push_back('{1'b0, addrs[i]});

      @(negedge clk);
      mode = md; base_addr = 15'(b); end_addr = 15'(e); stride = 15'(s);
      start = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      target = (dly >= 0) ? dly : int'($urandom_range(0, 3));
      while (!seen && cyc < 3000) begin
         if (done) begin
            seen = 1'b1;
            start = 1'b0; mem_ready = 1'b0;
            chk("done_lat", 64'(cyc), 64'((exp_q.size() == 0) ? 1 : last_cyc + 1));
            chk("done_strobes", {mem_read, mem_write}, 2'b00);
            chk("num_requests", 64'(idx), 64'(exp_q.size()));
`ifdef TRAFFIC_CHECK_EN
            exp_err = n_err;
`else
            exp_err = 0;
`endif
            chk("access_count", access_count, 64'(n_acc));
            chk("miss_count", miss_count, 64'(n_miss));
            chk("error_count", error_count, 64'(exp_err));
            chk("access_count4", access_count4, 64'(sat(n_acc, 4)));
            chk("miss_count4", miss_count4, 64'(sat(n_miss, 4)));
            chk("error_count4", error_count4, 64'(sat(exp_err, 4)));
         end else begin
            chk("busy_run", busy, 1'b1);
            // Inputs other than memory responses must be ignored while busy.
            start = 1'($urandom_range(0, 1)); mode = 1'($urandom);
            base_addr = 15'($urandom); end_addr = 15'($urandom); stride = 15'($urandom);
            if (mem_read || mem_write) begin
               if (idx >= exp_q.size()) begin
                  chk("extra_request", 1'b1, 1'b0);
                  mem_ready = 1'b1;
               end else begin
                  a = exp_q[idx].addr;
                  if (idx == 0 && waited == 0) chk("first_req_lat", 64'(cyc), 64'd1);
                  chk("address", mem_address, 64'(a));
                  chk("write_strobe", mem_write, exp_q[idx].wr);
                  chk("read_strobe", mem_read, !exp_q[idx].wr);
                  if (exp_q[idx].wr) chk("wdata", mem_wdata, pat(a));
                  if (waited == target) begin
                     mem_ready = 1'b1;
                     if (exp_q[idx].wr) begin
                        mem[a] = pat(a);
                        mem_hit = 1'($urandom);
                     end else begin
                        hit = (hitm == 0) ? 1'($urandom) : (hitm == 2);
                        mem_hit = hit;
                        if (!hit) n_miss++;
                        rd = mem.exists(a) ? mem[a] : $urandom;
                        if (a == bad) rd = rd ^ 32'd1;
                        mem_rdata = rd;
                        if (md && rd != pat(a)) n_err++;
                     end
                     n_acc++; idx++; waited = 0; last_cyc = cyc;
                     target = (dly >= 0) ? dly : int'($urandom_range(0, 3));
                  end else begin
                     mem_ready = 1'b0; mem_hit = 1'($urandom); mem_rdata = $urandom;
                     waited++;
                  end
               end
            end else begin
               mem_ready = 1'($urandom); mem_hit = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
         end
      end
      chk("done_seen", seen, 1'b1);
      @(negedge clk);
      chk("done_pulse_len", done, 1'b0);
      chk("busy_after", busy, 1'b0);
      chk("count_hold", access_count, 64'(n_acc));
   endtask

   initial begin
      int b, e, len, s;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_address", mem_address, 0);
      chk("rst_strobes", {mem_read, mem_write}, 2'b00);
      chk("rst_busy_done", {busy, done}, 2'b00);
      chk("rst_counts", {access_count, miss_count, error_count}, 0);
      rst = 1'b0;

      run(1'b0, 1024, 1027, 1, 0, 1, -1);
      run(1'b1, 0, 8, 4, 0, 2, -1);
      run(1'b1, 0, 8, 4, 0, 2, 4);
      run(1'b0, 1024, 1027, 1, 3, 1, -1);
      run(1'b1, 0, 8, 4, 3, 2, -1);
      run(1'b0, 32766, 32767, 3, 0, 0, -1);
      run(1'b1, 32765, 32767, 1, 1, 0, 32766);
      run(1'b0, 10, 5, 1, 0, 0, -1);
      run(1'b0, 5, 8, 0, 0, 0, -1);
      run(1'b1, 100, 100, 7, 0, 0, -1);
      run(1'b0, 0, 19, 1, 0, 1, -1);

      for (int k = 0; k < 10; k++) begin
         b   = int'($urandom_range(0, 32767));
         len = int'($urandom_range(0, 30));
         e   = (b + len > 32767) ? 32767 : b + len;
         if ($urandom_range(0, 5) == 0 && b > 0) e = b - 1;
         s   = int'($urandom_range(0, 6));
         run(1'($urandom), b, e, s, -1, 0, b + ((s == 0) ? 1 : s));
      end

      // Reset in the middle of the read pass of a write-then-read run.
      @(negedge clk);
      mode = 1'b1; base_addr = 15'd0; end_addr = 15'd20; stride = 15'd1;
      mem_ready = 1'b1; mem_hit = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      chk("mid_rd_pass", {mem_read, mem_write}, 2'b10);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_address", mem_address, 0);
      chk("midrst_wdata", mem_wdata, 0);
      chk("midrst_strobes", {mem_read, mem_write}, 2'b00);
      chk("midrst_busy_done", {busy, done}, 2'b00);
      chk("midrst_counts", {access_count, miss_count, error_count}, 0);
      rst = 1'b0;

      // Reset and start together: reset wins.
      mem_ready = 1'b0; base_addr = 15'd0; end_addr = 15'd3; mode = 1'b0;
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_over_start_busy", busy, 1'b0);
      chk("rst_over_start_rd", mem_read, 1'b0);
      @(negedge clk);
      chk("rst_over_start_idle", {busy, mem_read}, 2'b00);

      run(1'b1, 200, 212, 2, -1, 0, 204);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
